axis_stream_checker: RTL and testbench

- Synthesizable AXI-Stream subordinate that terminates the NI's manager (network_s_axis) side of a tile and self-checks the traffic the NoC delivers.
- Receiving counterpart of the tile's AXIS traffic generator: it checks destination, source identity, per-source packet sequence and beat ordering.
- Applies optional pseudo-random backpressure and exposes counters and sticky error flags to the bench.

---
 rtl/axis_stream_checker.sv | 258 +++++++++++++++++++++++++
 tb/tb_axis_stream_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : axis_stream_checker
// Description : AXI-Stream subordinate that terminates the NI manager side of
//               a tile and checks delivered traffic: destination, source id,
//               per-source packet sequence, beat ordering and packet length.
//               Optional LFSR-driven backpressure on a registered tready.
// Ports       : clk_s_axis_i / rst_s_axis_ni  clock, async active-low reset
//               clear_i                        sync clear of checker state
//               s_axis_*                       AXI-Stream subordinate port
//               pkt_count_o / beat_count_o     packets / beats accepted
//               error_count_o                  erroneous beats (saturating)
//               error_flags_o                  sticky check-failure bits
//               busy_o                         high while inside a packet
// Revision    : 1.0  initial release
// ============================================================================
module axis_stream_checker #(
    parameter int          TDataWidth         = 64,
    parameter int          TIdWidth           = 8,
    parameter int          TDestWidth         = 8,
    parameter int          ExpectedTDest      = 0,
    parameter int          NumSources         = 16,
    parameter int          MaxPacketBeats     = 16,
    parameter int          BackpressureEnable = 1,
    parameter logic [15:0] LfsrSeed           = 16'hACE1
) (
    input  logic                  clk_s_axis_i,
    input  logic                  rst_s_axis_ni,
    input  logic                  clear_i,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [TDataWidth-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic [TIdWidth-1:0]   s_axis_tid,
    input  logic [TDestWidth-1:0] s_axis_tdest,
    output logic [31:0]           pkt_count_o,
    output logic [31:0]           beat_count_o,
    output logic [15:0]           error_count_o,
    output logic [5:0]            error_flags_o,
    output logic                  busy_o
);

    localparam int         c_SRC_W     = (NumSources > 1) ? $clog2(NumSources) : 1;
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_IN_PKT = 1'b1;

    // ------------------------------------------------------------------
    // Backpressure: Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifted right.
    // ------------------------------------------------------------------
    logic [15:0] lfsr_q, lfsr_d;
    logic        tready_q, tready_d;

    always_comb lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    generate
        if (BackpressureEnable != 0) begin : g_bp
            always_comb tready_d = lfsr_q[0] | lfsr_q[1];
        end else begin : g_no_bp
            always_comb tready_d = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk_s_axis_i or negedge rst_s_axis_ni) begin
        if (!rst_s_axis_ni) begin
            lfsr_q   <= LfsrSeed;
            tready_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            tready_q <= tready_d;
        end
    end

    assign s_axis_tready = tready_q;

    // ------------------------------------------------------------------
    // Beat decode
    // ------------------------------------------------------------------
    logic [7:0] w_tid8;

    generate
        if (TIdWidth >= 8) begin : g_tid_trunc
            assign w_tid8 = s_axis_tid[7:0];
        end else begin : g_tid_ext
            assign w_tid8 = {{(8 - TIdWidth){1'b0}}, s_axis_tid};
        end
        if (TDataWidth > 32) begin : g_data_hi
            logic w_unused_hi;
            assign w_unused_hi = ^s_axis_tdata[TDataWidth-1:32];
        end
    endgenerate

    logic [0:0]          state_q, state_d;
    logic [TIdWidth-1:0] cur_tid_q, cur_tid_d;
    logic                cur_ok_q, cur_ok_d;
    logic [15:0]         cur_seq_q, cur_seq_d;
    logic [7:0]          exp_idx_q, exp_idx_d;
    logic [8:0]          beat_cnt_q, beat_cnt_d;
    logic [31:0]         pkt_count_q, pkt_count_d;
    logic [31:0]         beat_count_q, beat_count_d;
    logic [15:0]         error_count_q, error_count_d;
    logic [5:0]          error_flags_q, error_flags_d;
    logic [15:0]         seq_table_q [NumSources];
    logic [15:0]         seq_table_d [NumSources];

    logic               w_accept;
    logic               w_first;
    logic               w_tid_ok;
    logic [c_SRC_W-1:0] w_tid_idx;
    logic [c_SRC_W-1:0] w_pkt_idx;
    logic               w_pkt_ok;
    logic [15:0]        w_pkt_seq;
    logic [7:0]         w_exp_idx;
    logic [8:0]         w_beat_num;
    logic [5:0]         w_err;

    assign w_accept   = s_axis_tvalid & tready_q;
    assign w_first    = (state_q == c_ST_IDLE);
    assign w_tid_ok   = 32'(s_axis_tid) < 32'(NumSources);
    assign w_tid_idx  = c_SRC_W'(s_axis_tid);
    // Packet-level identity: taken from the live beat on a first beat,
    // otherwise from what was latched when the packet opened.
    assign w_pkt_idx  = w_first ? w_tid_idx : c_SRC_W'(cur_tid_q);
    assign w_pkt_ok   = w_first ? w_tid_ok : cur_ok_q;
    assign w_pkt_seq  = w_first ? s_axis_tdata[31:16] : cur_seq_q;
    assign w_exp_idx  = w_first ? 8'd0 : exp_idx_q;
    assign w_beat_num = w_first ? 9'd1 : beat_cnt_q + 9'd1;

    always_comb begin
        w_err    = '0;
        w_err[0] = s_axis_tdest != TDestWidth'(ExpectedTDest);
        w_err[1] = !w_tid_ok;
        w_err[2] = !w_first && (s_axis_tid != cur_tid_q);
        w_err[3] = s_axis_tdata[15:8] != w_tid8;
        w_err[4] = (s_axis_tdata[7:0] != w_exp_idx) ||
                   (w_first && w_tid_ok && (s_axis_tdata[31:16] != seq_table_q[w_tid_idx]));
        // beat_cnt saturates at MaxPacketBeats, so this matches once per packet
        w_err[5] = !s_axis_tlast && (w_beat_num == 9'(MaxPacketBeats));
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_s_axis_i or negedge rst_s_axis_ni) begin
        if (!rst_s_axis_ni) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = c_ST_IDLE;
        end else if (w_accept) begin
            if (w_first && !s_axis_tlast) begin
                state_d = c_ST_IN_PKT;
            end else if (!w_first && s_axis_tlast) begin
                state_d = c_ST_IDLE;
            end
        end
    end

    always_comb begin
        busy_o = (state_q == c_ST_IN_PKT);
    end

    // ------------------------------------------------------------------
    // Counters, flags and sequence table
    // ------------------------------------------------------------------
    always_comb begin
        cur_tid_d     = cur_tid_q;
        cur_ok_d      = cur_ok_q;
        cur_seq_d     = cur_seq_q;
        exp_idx_d     = exp_idx_q;
        beat_cnt_d    = beat_cnt_q;
        pkt_count_d   = pkt_count_q;
        beat_count_d  = beat_count_q;
        error_count_d = error_count_q;
        error_flags_d = error_flags_q;
        seq_table_d   = seq_table_q;
        if (clear_i) begin
            cur_tid_d     = '0;
            cur_ok_d      = 1'b0;
            cur_seq_d     = '0;
            exp_idx_d     = '0;
            beat_cnt_d    = '0;
            pkt_count_d   = '0;
            beat_count_d  = '0;
            error_count_d = '0;
            error_flags_d = '0;
            for (int i = 0; i < NumSources; i++) begin
                seq_table_d[i] = '0;
            end
        end else if (w_accept) begin
            beat_count_d  = beat_count_q + 32'd1;
            error_flags_d = error_flags_q | w_err;
            if ((|w_err) && (error_count_q != 16'hFFFF)) begin
                error_count_d = error_count_q + 16'd1;
            end
            if (w_first) begin
                cur_tid_d  = s_axis_tid;
                cur_ok_d   = w_tid_ok;
                cur_seq_d  = s_axis_tdata[31:16];
                exp_idx_d  = 8'd1;
                beat_cnt_d = 9'd1;
            end else begin
                exp_idx_d  = exp_idx_q + 8'd1;
                beat_cnt_d = (w_beat_num > 9'(MaxPacketBeats)) ? beat_cnt_q : w_beat_num;
            end
            if (s_axis_tlast) begin
                pkt_count_d = pkt_count_q + 32'd1;
                // Resynchronise to the sequence actually received, so a
                // skipped packet costs exactly one ORDER error.
                if (w_pkt_ok) begin
                    seq_table_d[w_pkt_idx] = w_pkt_seq + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_s_axis_i or negedge rst_s_axis_ni) begin
        if (!rst_s_axis_ni) begin
            cur_tid_q     <= '0;
            cur_ok_q      <= 1'b0;
            cur_seq_q     <= '0;
            exp_idx_q     <= '0;
            beat_cnt_q    <= '0;
            pkt_count_q   <= '0;
            beat_count_q  <= '0;
            error_count_q <= '0;
            error_flags_q <= '0;
            for (int i = 0; i < NumSources; i++) begin
                seq_table_q[i] <= '0;
            end
        end else begin
            cur_tid_q     <= cur_tid_d;
            cur_ok_q      <= cur_ok_d;
            cur_seq_q     <= cur_seq_d;
            exp_idx_q     <= exp_idx_d;
            beat_cnt_q    <= beat_cnt_d;
            pkt_count_q   <= pkt_count_d;
            beat_count_q  <= beat_count_d;
            error_count_q <= error_count_d;
            error_flags_q <= error_flags_d;
            for (int i = 0; i < NumSources; i++) begin
                seq_table_q[i] <= seq_table_d[i];
            end
        end
    end

    assign pkt_count_o   = pkt_count_q;
    assign beat_count_o  = beat_count_q;
    assign error_count_o = error_count_q;
    assign error_flags_o = error_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_stream_checker
// Description : Directed bench for axis_stream_checker. One instance without
//               backpressure runs a vector table plus a mid-packet reset; a
//               second instance with backpressure streams 1000 packets and
//               is cleared mid-stream.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axis_stream_checker;

    typedef struct {
        logic        clr;
        logic        vld;
        logic        last;
        logic [7:0]  tid;
        logic [7:0]  dest;
        logic [7:0]  idx;
        logic [7:0]  ptid;
        logic [15:0] seq;
        logic [31:0] e_pkt;
        logic [31:0] e_beat;
        logic [15:0] e_err;
        logic [5:0]  e_flags;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance without backpressure
    logic        clr = 1'b0, vld = 1'b0, last = 1'b0, rdy;
    logic [63:0] tdata = '0;
    logic [7:0]  tid = '0, tdest = '0;
    logic [31:0] pkt, beat;
    logic [15:0] err;
    logic [5:0]  flags;
    logic        busy;

    // instance with backpressure
    logic        b_clr = 1'b0, b_vld = 1'b0, b_last = 1'b0, b_rdy;
    logic [63:0] b_tdata = '0;
    logic [7:0]  b_tid = '0, b_tdest = '0;
    logic [31:0] b_pkt, b_beat;
    logic [15:0] b_err;
    logic [5:0]  b_flags;
    logic        b_busy;

    axis_stream_checker #(.BackpressureEnable(0)) u_dut (
        .clk_s_axis_i (clk),   .rst_s_axis_ni(rst_n), .clear_i(clr),
        .s_axis_tvalid(vld),   .s_axis_tready(rdy),   .s_axis_tdata(tdata),
        .s_axis_tlast (last),  .s_axis_tid   (tid),   .s_axis_tdest(tdest),
        .pkt_count_o  (pkt),   .beat_count_o (beat),  .error_count_o(err),
        .error_flags_o(flags), .busy_o       (busy)
    );

    axis_stream_checker #(.BackpressureEnable(1)) u_dut_bp (
        .clk_s_axis_i (clk),     .rst_s_axis_ni(rst_n),  .clear_i(b_clr),
        .s_axis_tvalid(b_vld),   .s_axis_tready(b_rdy),  .s_axis_tdata(b_tdata),
        .s_axis_tlast (b_last),  .s_axis_tid   (b_tid),  .s_axis_tdest(b_tdest),
        .pkt_count_o  (b_pkt),   .beat_count_o (b_beat), .error_count_o(b_err),
        .error_flags_o(b_flags), .busy_o       (b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic v, input logic l, input logic [7:0] t,
                       input logic [7:0] d, input logic [7:0] i, input logic [7:0] pt,
                       input logic [15:0] s, input logic [31:0] ep, input logic [31:0] eb,
                       input logic [15:0] ee, input logic [5:0] ef, input logic eby);
        vec_t x;
        x.clr = c; x.vld = v; x.last = l; x.tid = t; x.dest = d; x.idx = i; x.ptid = pt;
        x.seq = s; x.e_pkt = ep; x.e_beat = eb; x.e_err = ee; x.e_flags = ef; x.e_busy = eby;
        vecs.push_back(x);
    endtask

    task automatic drive(input logic c, input logic v, input logic l, input logic [7:0] t,
                         input logic [7:0] d, input logic [7:0] i, input logic [7:0] pt,
                         input logic [15:0] s);
        clr = c; vld = v; last = l; tid = t; tdest = d;
        tdata = {32'h0, s, pt, i};
    endtask

    task automatic drive_bp(input logic c, input logic [15:0] s);
        b_clr = c; b_vld = 1'b1; b_last = 1'b1; b_tid = 8'd0; b_tdest = 8'd0;
        b_tdata = {32'h0, s, 8'd0, 8'd0};
    endtask

    initial begin
        // ---- Vector table ----
        // A: tid 3, four 5-beat packets, seq 0..3, all clean
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 5; j++)
                add(0, 1, j == 4, 8'd3, 8'd0, 8'(j), 8'd3, 16'(p),
                    32'(p + ((j == 4) ? 1 : 0)), 32'(5 * p + j + 1), 16'd0, 6'd0, j != 4);
        // clear with a bad beat offered in the same cycle: discarded
        add(1, 1, 0, 8'd3, 8'd7, 8'd0, 8'd3, 16'd0, 0, 0, 0, 6'd0, 0);
        // B: wrong tdest, 3 beats; table was cleared so seq 0 is correct
        for (int j = 0; j < 3; j++)
            add(0, 1, j == 2, 8'd3, 8'd2, 8'(j), 8'd3, 16'd0,
                32'((j == 2) ? 1 : 0), 32'(j + 1), 16'(j + 1), 6'b000001, j != 2);
        add(1, 0, 0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 0, 0, 0, 6'd0, 0);
        // C: tid 5, seq 0, then seq 2 (gap), then seq 3
        add(0, 1, 0, 8'd5, 8'd0, 8'd0, 8'd5, 16'd0, 0, 1, 0, 6'd0, 1);
        add(0, 1, 1, 8'd5, 8'd0, 8'd1, 8'd5, 16'd0, 1, 2, 0, 6'd0, 0);
        add(0, 1, 0, 8'd5, 8'd0, 8'd0, 8'd5, 16'd2, 1, 3, 1, 6'b010000, 1);
        add(0, 1, 1, 8'd5, 8'd0, 8'd1, 8'd5, 16'd2, 2, 4, 1, 6'b010000, 0);
        add(0, 1, 0, 8'd5, 8'd0, 8'd0, 8'd5, 16'd3, 2, 5, 1, 6'b010000, 1);
        add(0, 1, 1, 8'd5, 8'd0, 8'd1, 8'd5, 16'd3, 3, 6, 1, 6'b010000, 0);
        add(1, 0, 0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 0, 0, 0, 6'd0, 0);
        // D: 17-beat packet, tid 1, with an idle gap after beat 5
        for (int j = 0; j < 17; j++) begin
            add(0, 1, j == 16, 8'd1, 8'd0, 8'(j), 8'd1, 16'd0,
                32'((j == 16) ? 1 : 0), 32'(j + 1), 16'((j >= 15) ? 1 : 0),
                (j >= 15) ? 6'b100000 : 6'b000000, j != 16);
            if (j == 4)
                add(0, 0, 0, 8'd1, 8'd0, 8'd5, 8'd1, 16'd0, 0, 5, 0, 6'd0, 1);
        end
        add(1, 0, 0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 0, 0, 0, 6'd0, 0);
        // E: tid change 1->2 with payload tid 2 (TID_CHANGE only)
        add(0, 1, 0, 8'd1, 8'd0, 8'd0, 8'd1, 16'd0, 0, 1, 0, 6'd0, 1);
        add(0, 1, 0, 8'd2, 8'd0, 8'd1, 8'd2, 16'd0, 0, 2, 1, 6'b000100, 1);
        add(0, 1, 1, 8'd1, 8'd0, 8'd2, 8'd1, 16'd0, 1, 3, 1, 6'b000100, 0);
        //    tid change with payload still carrying tid 1 (adds PAYLOAD_ID)
        add(0, 1, 0, 8'd1, 8'd0, 8'd0, 8'd1, 16'd1, 1, 4, 1, 6'b000100, 1);
        add(0, 1, 1, 8'd2, 8'd0, 8'd1, 8'd1, 16'd1, 2, 5, 2, 6'b001100, 0);
        //    out-of-range tid: sequence not checked
        add(0, 1, 1, 8'd16, 8'd0, 8'd0, 8'd16, 16'd99, 3, 6, 3, 6'b001110, 0);
        //    wrong beat index on a single-beat packet
        add(0, 1, 1, 8'd1, 8'd0, 8'd3, 8'd1, 16'd2, 4, 7, 4, 6'b011110, 0);

        // ---- Reset state ----
        #12;
        n_vec++;
        chk("rst_tready", 32'(rdy), 0);
        chk("rst_pkt", pkt, 0);
        chk("rst_beat", beat, 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bp_tready", 32'(b_rdy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        chk("tready_after_rst", 32'(rdy), 1);

        // ---- Apply table ----
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].clr, vecs[k].vld, vecs[k].last, vecs[k].tid, vecs[k].dest,
                  vecs[k].idx, vecs[k].ptid, vecs[k].seq);
            @(posedge clk); #1;
            n_vec++;
            chk($sformatf("v%0d_pkt", k), pkt, vecs[k].e_pkt);
            chk($sformatf("v%0d_beat", k), beat, vecs[k].e_beat);
            chk($sformatf("v%0d_err", k), 32'(err), 32'(vecs[k].e_err));
            chk($sformatf("v%0d_flags", k), 32'(flags), 32'(vecs[k].e_flags));
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].e_busy));
            chk($sformatf("v%0d_tready", k), 32'(rdy), 1);
        end

        // ---- Asynchronous reset in the middle of a packet ----
        drive(1, 0, 0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0);
        @(posedge clk); #1;
        drive(0, 1, 0, 8'd3, 8'd0, 8'd0, 8'd3, 16'd0);
        @(posedge clk); #1;
        n_vec++;
        chk("midrst_busy_before", 32'(busy), 1);
        drive(0, 0, 0, 8'd3, 8'd0, 8'd1, 8'd3, 16'd0);
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        chk("midrst_beat", beat, 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_tready", 32'(rdy), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(0, 1, 1, 8'd3, 8'd0, 8'd0, 8'd3, 16'd0);
        @(posedge clk); #1;
        n_vec++;
        chk("postrst_pkt", pkt, 1);
        chk("postrst_beat", beat, 1);
        chk("postrst_err", 32'(err), 0);
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0);

        // ---- Backpressure: 1000 single-beat packets ----
        begin
            int   acc;
            int   cyc;
            int   duty;
            logic r;
            acc = 0;
            cyc = 0;
            while (acc < 1000 && cyc < 5000) begin
                drive_bp(0, 16'(acc));
                r = b_rdy;
                @(posedge clk); #1;
                cyc++;
                if (r) acc++;
            end
            duty = (cyc > 0) ? (acc * 100) / cyc : 0;
            n_vec++;
            chk("bp_all_accepted", 32'(acc), 1000);
            chk("bp_duty_70_80", 32'((duty >= 70) && (duty <= 80)), 1);
            chk("bp_pkt", b_pkt, 1000);
            chk("bp_beat", b_beat, 1000);
            chk("bp_err", 32'(b_err), 0);
            chk("bp_flags", 32'(b_flags), 0);
            // keep streaming, then clear in the middle
            for (int i = 0; i < 20; i++) begin
                drive_bp(0, 16'(acc));
                r = b_rdy;
                @(posedge clk); #1;
                if (r) acc++;
            end
            drive_bp(1, 16'(acc));
            @(posedge clk); #1;
            n_vec++;
            chk("bpclr_pkt", b_pkt, 0);
            chk("bpclr_beat", b_beat, 0);
            chk("bpclr_err", 32'(b_err), 0);
            chk("bpclr_flags", 32'(b_flags), 0);
            chk("bpclr_busy", 32'(b_busy), 0);
            // first packet after clear must carry sequence 0
            acc = 0;
            cyc = 0;
            while (acc < 1 && cyc < 100) begin
                drive_bp(0, 16'd0);
                r = b_rdy;
                @(posedge clk); #1;
                cyc++;
                if (r) acc++;
            end
            b_vld = 1'b0;
            n_vec++;
            chk("bpclr_next_accepted", 32'(acc), 1);
            chk("bpclr_next_pkt", b_pkt, 1);
            chk("bpclr_next_err", 32'(b_err), 0);
            chk("bpclr_next_flags", 32'(b_flags), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
